// File: rtl/wb_afe_regs_pkg.sv
// Shared definitions for the AFE control register block:
// register offsets, bit positions, FSM states and byte-lane merge.
`timescale 1ns/1ps
package wb_afe_regs_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_GAIN   = 8'h04;
    localparam logic [7:0] OFF_WIN    = 8'h08;
    localparam logic [7:0] OFF_RESULT = 8'h0C;
    localparam logic [7:0] OFF_STATUS = 8'h10;
    localparam logic [7:0] OFF_ID     = 8'h14;

    localparam int CTRL_VCO_EN = 0;
    localparam int CTRL_VGA_EN = 1;
    localparam int CTRL_START  = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVF  = 2;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } fsm_e;

    function automatic logic [31:0] apply_sel(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (sel[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/wb_afe_regs_if.sv
// Wishbone classic slave-side bundle between the management SoC
// and the AFE register block.
`timescale 1ns/1ps
interface wb_afe_regs_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i,
        output wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
        input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_afe_regs_sync_edge_det.sv
// Two-flop synchronizer for the divided VCO clock followed by a
// registered rising-edge pulse (3 cycles from input to pulse).
`timescale 1ns/1ps
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic pulse_o
);
    logic s1_q, s2_q, s3_q, pulse_q;
    logic pulse_d;

    always_comb pulse_d = s2_q & ~s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= d_i;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;
endmodule

// File: rtl/wb_afe_regs.sv
// Wishbone register block for the analog AFE: enables, VGA gain and a
// gated frequency counter on the divided VCO with a done interrupt.
`timescale 1ns/1ps
module wb_afe_regs
    import wb_afe_regs_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          GAIN_W    = 6,
    parameter int          CNT_W     = 24,
    parameter int          WIN_W     = CNT_W,
    parameter logic [31:0] ID_VALUE  = 32'h5643_4F01
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    wb_afe_regs_if.slave      wbs,
    input  logic              vco_div_i,
    output logic              vco_en_o,
    output logic              vga_en_o,
    output logic [GAIN_W-1:0] vga_gain_o,
    output logic              irq_o
);
    logic              ack_q, ack_d, we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [7:0]        off_q, off_d;
    logic [31:0]       wdat_q, wdat_d;
    logic              vco_en_q, vco_en_d, vga_en_q, vga_en_d;
    logic              irq_en_q, irq_en_d, irq_q, irq_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [WIN_W-1:0]  win_cfg_q, win_cfg_d, win_q, win_d;
    logic [CNT_W-1:0]  ecnt_q, ecnt_d, result_q, result_d;
    logic              done_q, done_d, ovf_q, ovf_d;
    fsm_e              state_q, state_d;

    logic        req, wr, wr_ctrl0, start, edge_p;
    logic        done_set, ovf_set, clr_done, clr_ovf;
    logic [31:0] rdata;

    sync_edge_det u_sync (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .d_i     (vco_div_i),
        .pulse_o (edge_p)
    );

    always_comb begin
        req = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q
            & (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        ack_d  = req;
        // Latch the request so a dropped strobe still completes.
        we_d   = req ? wbs.wbs_we_i        : we_q;
        sel_d  = req ? wbs.wbs_sel_i       : sel_q;
        off_d  = req ? wbs.wbs_adr_i[7:0]  : off_q;
        wdat_d = req ? wbs.wbs_dat_i       : wdat_q;

        wr       = ack_q & we_q;
        wr_ctrl0 = wr & (off_q == OFF_CTRL) & sel_q[0];
        start    = wr_ctrl0 & wdat_q[CTRL_START];
        vco_en_d = wr_ctrl0 ? wdat_q[CTRL_VCO_EN] : vco_en_q;
        vga_en_d = wr_ctrl0 ? wdat_q[CTRL_VGA_EN] : vga_en_q;
        irq_en_d = wr_ctrl0 ? wdat_q[CTRL_IRQ_EN] : irq_en_q;

        gain_d = gain_q;
        if (wr && off_q == OFF_GAIN)
            gain_d = GAIN_W'(apply_sel(32'(gain_q), wdat_q, sel_q));
        win_cfg_d = win_cfg_q;
        if (wr && off_q == OFF_WIN)
            win_cfg_d = WIN_W'(apply_sel(32'(win_cfg_q), wdat_q, sel_q));

        state_d  = state_q;
        win_d    = win_q;
        ecnt_d   = ecnt_q;
        result_d = result_q;
        done_set = 1'b0;
        ovf_set  = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                win_d   = win_cfg_q;
                ecnt_d  = '0;
                state_d = (win_cfg_q == '0) ? DONE : COUNT;
            end
            COUNT: begin
                win_d = win_q - WIN_W'(1);
                if (edge_p) begin
                    if (&ecnt_q) ovf_set = 1'b1;
                    else         ecnt_d  = ecnt_q + CNT_W'(1);
                end
                if (win_q <= WIN_W'(1)) state_d = DONE;
            end
            DONE: begin
                result_d = ecnt_q;
                done_set = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        clr_done = wr & (off_q == OFF_STATUS) & sel_q[0] & wdat_q[STAT_DONE];
        clr_ovf  = wr & (off_q == OFF_STATUS) & sel_q[0] & wdat_q[STAT_OVF];
        done_d   = done_set | (done_q & ~clr_done);
        ovf_d    = ovf_set  | (ovf_q  & ~clr_ovf);
        irq_d    = irq_en_q & done_q;

        rdata = '0;
        case (off_q)
            OFF_CTRL:   rdata = 32'({irq_en_q, 1'b0, vga_en_q, vco_en_q});
            OFF_GAIN:   rdata = 32'(gain_q);
            OFF_WIN:    rdata = 32'(win_cfg_q);
            OFF_RESULT: rdata = 32'(result_q);
            OFF_STATUS: rdata = 32'({ovf_q, done_q, state_q == COUNT});
            OFF_ID:     rdata = ID_VALUE;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            off_q     <= '0;
            wdat_q    <= '0;
            vco_en_q  <= 1'b0;
            vga_en_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
            gain_q    <= '0;
            win_cfg_q <= '0;
            win_q     <= '0;
            ecnt_q    <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            state_q   <= IDLE;
        end else begin
            ack_q     <= ack_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            off_q     <= off_d;
            wdat_q    <= wdat_d;
            vco_en_q  <= vco_en_d;
            vga_en_q  <= vga_en_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
            gain_q    <= gain_d;
            win_cfg_q <= win_cfg_d;
            win_q     <= win_d;
            ecnt_q    <= ecnt_d;
            result_q  <= result_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = ack_q ? rdata : '0;
    assign vco_en_o      = vco_en_q;
    assign vga_en_o      = vga_en_q;
    assign vga_gain_o    = gain_q;
    assign irq_o         = irq_q;
endmodule

// File: tb/tb_wb_afe_regs.sv
// Directed bench for wb_afe_regs: a register-access vector table plus
// hand-written measurement, overflow, interrupt and reset sequences.
`timescale 1ns/1ps
module tb_wb_afe_regs;
    import wb_afe_regs_pkg::*;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vco = 1'b0;
    bit   vco_run = 1'b0;
    int   vhalf = 50;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always begin
        #(vhalf);
        if (vco_run) vco = ~vco;
    end

    wb_afe_regs_if ifa ();
    wb_afe_regs_if ifb ();

    logic       a_vco_en, a_vga_en, a_irq;
    logic [5:0] a_gain;
    logic       b_vco_en, b_vga_en, b_irq;
    logic [5:0] b_gain;

    wb_afe_regs #(.CNT_W(24)) dut_a (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs        (ifa),
        .vco_div_i  (vco),
        .vco_en_o   (a_vco_en),
        .vga_en_o   (a_vga_en),
        .vga_gain_o (a_gain),
        .irq_o      (a_irq)
    );

    wb_afe_regs #(.CNT_W(4), .WIN_W(24)) dut_b (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs        (ifb),
        .vco_div_i  (vco),
        .vco_en_o   (b_vco_en),
        .vga_en_o   (b_vga_en),
        .vga_gain_o (b_gain),
        .irq_o      (b_irq)
    );

    typedef struct {
        bit          we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        bit          exp_ack;
        bit          chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input bit b, input bit we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] dat,
                       output bit ack, output logic [31:0] rd,
                       output bit late);
        cyc1();
        ifa.wbs_we_i  = we;   ifb.wbs_we_i  = we;
        ifa.wbs_sel_i = sel;  ifb.wbs_sel_i = sel;
        ifa.wbs_adr_i = adr;  ifb.wbs_adr_i = adr;
        ifa.wbs_dat_i = dat;  ifb.wbs_dat_i = dat;
        ifa.wbs_stb_i = !b;   ifa.wbs_cyc_i = !b;
        ifb.wbs_stb_i = b;    ifb.wbs_cyc_i = b;
        cyc1();
        ack = b ? ifb.wbs_ack_o : ifa.wbs_ack_o;
        rd  = b ? ifb.wbs_dat_o : ifa.wbs_dat_o;
        ifa.wbs_stb_i = 1'b0; ifa.wbs_cyc_i = 1'b0;
        ifb.wbs_stb_i = 1'b0; ifb.wbs_cyc_i = 1'b0;
        cyc1();
        late = b ? ifb.wbs_ack_o : ifa.wbs_ack_o;
    endtask

    task automatic wr(input bit b, input logic [7:0] off,
                      input logic [31:0] d, input string nm);
        bit ack, late;
        logic [31:0] rd;
        bus(b, 1'b1, 4'hF, BASE | 32'(off), d, ack, rd, late);
        chk({nm, "_ack"}, 32'(ack), 32'd1);
    endtask

    task automatic rdc(input bit b, input logic [7:0] off,
                       input logic [31:0] exp, input string nm);
        bit ack, late;
        logic [31:0] rd;
        bus(b, 1'b0, 4'hF, BASE | 32'(off), 32'h0, ack, rd, late);
        chk({nm, "_ack"}, 32'(ack), 32'd1);
        chk(nm, rd, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ack, late;
        logic [31:0] rd;
        time t0;
        int n;

        ifa.wbs_stb_i = 0; ifa.wbs_cyc_i = 0; ifa.wbs_we_i = 0;
        ifa.wbs_sel_i = 0; ifa.wbs_adr_i = 0; ifa.wbs_dat_i = 0;
        ifb.wbs_stb_i = 0; ifb.wbs_cyc_i = 0; ifb.wbs_we_i = 0;
        ifb.wbs_sel_i = 0; ifb.wbs_adr_i = 0; ifb.wbs_dat_i = 0;

        tbl[0]  = '{0, 4'hF, BASE + 32'h14,  32'h0,         1, 1, 32'h5643_4F01};
        tbl[1]  = '{1, 4'h1, BASE + 32'h04,  32'hFFFF_FFFF, 1, 0, 32'h0};
        tbl[2]  = '{0, 4'hF, BASE + 32'h04,  32'h0,         1, 1, 32'h0000_003F};
        tbl[3]  = '{1, 4'h2, BASE + 32'h04,  32'hFFFF_FFFF, 1, 0, 32'h0};
        tbl[4]  = '{0, 4'hF, BASE + 32'h04,  32'h0,         1, 1, 32'h0000_003F};
        tbl[5]  = '{1, 4'hF, BASE + 32'h04,  32'h0000_0015, 1, 0, 32'h0};
        tbl[6]  = '{0, 4'hF, BASE + 32'h04,  32'h0,         1, 1, 32'h0000_0015};
        tbl[7]  = '{1, 4'h1, BASE + 32'h00,  32'h0000_000B, 1, 0, 32'h0};
        tbl[8]  = '{0, 4'hF, BASE + 32'h00,  32'h0,         1, 1, 32'h0000_000B};
        tbl[9]  = '{1, 4'hF, BASE + 32'h08,  32'h0000_03E8, 1, 0, 32'h0};
        tbl[10] = '{1, 4'h4, BASE + 32'h08,  32'hAABB_CCDD, 1, 0, 32'h0};
        tbl[11] = '{0, 4'hF, BASE + 32'h08,  32'h0,         1, 1, 32'h00BB_03E8};
        tbl[12] = '{1, 4'hF, BASE + 32'h08,  32'h0000_03E8, 1, 0, 32'h0};
        tbl[13] = '{0, 4'hF, BASE + 32'h0C,  32'h0,         1, 1, 32'h0};
        tbl[14] = '{0, 4'hF, BASE + 32'h10,  32'h0,         1, 1, 32'h0};
        tbl[15] = '{0, 4'hF, BASE + 32'h40,  32'h0,         1, 1, 32'h0};
        tbl[16] = '{1, 4'hF, BASE + 32'h40,  32'hFFFF_FFFF, 1, 0, 32'h0};
        tbl[17] = '{0, 4'hF, BASE + 32'h100, 32'h0,         0, 1, 32'h0};
        tbl[18] = '{1, 4'hF, BASE + 32'h100, 32'hFFFF_FFFF, 0, 0, 32'h0};

        // Reset state
        #22;
        chk("rst_a_outs", {a_vco_en, a_vga_en, a_irq, a_gain}, 32'h0);
        chk("rst_b_outs", {b_vco_en, b_vga_en, b_irq, b_gain}, 32'h0);
        chk("rst_ack", {ifa.wbs_ack_o, ifb.wbs_ack_o}, 32'h0);
        #11;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            bus(1'b0, tbl[i].we, tbl[i].sel, tbl[i].adr, tbl[i].dat,
                ack, rd, late);
            chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(tbl[i].exp_ack));
            chk($sformatf("vec%0d_ack_1cyc", i), 32'(late), 32'd0);
            if (tbl[i].chk_dat)
                chk($sformatf("vec%0d_dat", i), rd, tbl[i].exp_dat);
        end
        chk("outs_after_tbl", {a_vco_en, a_vga_en, a_irq, a_gain},
            {23'h0, 1'b1, 1'b1, 1'b0, 6'h15});

        // Measurement on A: WIN=1000, period 10, restart attempt ignored
        vhalf = 50;
        vco_run = 1'b1;
        wr(1'b0, OFF_CTRL, 32'h0F, "start_a");
        t0 = $time;
        repeat (100) cyc1();
        rdc(1'b0, OFF_STATUS, 32'h1, "busy_mid");
        wr(1'b0, OFF_CTRL, 32'h0F, "restart_busy");
        n = 0;
        while (!a_irq && n < 3000) begin
            cyc1();
            n++;
        end
        chk("meas_cycles", 32'(($time - t0) / 10), 32'd1002);
        bus(1'b0, 1'b0, 4'hF, BASE + 32'h0C, 32'h0, ack, rd, late);
        checks++;
        if (rd < 32'd99 || rd > 32'd101) begin
            failures++;
            $display("FAIL result_100: got %0d expected 99..101", rd);
        end
        rdc(1'b0, OFF_STATUS, 32'h2, "status_done");
        chk("irq_done", 32'(a_irq), 32'd1);
        wr(1'b0, OFF_STATUS, 32'h2, "w1c_done");
        chk("irq_hold", 32'(a_irq), 32'd1);
        cyc1();
        chk("irq_drop", 32'(a_irq), 32'd0);
        rdc(1'b0, OFF_STATUS, 32'h0, "status_clr");

        // Overflow on B: 4-bit result, WIN=100, period 4
        vhalf = 20;
        wr(1'b1, OFF_WIN, 32'd100, "win_b");
        wr(1'b1, OFF_CTRL, 32'h0C, "start_b");
        t0 = $time;
        n = 0;
        while (!b_irq && n < 1000) begin
            cyc1();
            n++;
        end
        chk("meas_cycles_b", 32'(($time - t0) / 10), 32'd102);
        rdc(1'b1, OFF_RESULT, 32'hF, "result_sat");
        rdc(1'b1, OFF_STATUS, 32'h6, "status_ovf");
        wr(1'b1, OFF_STATUS, 32'h6, "w1c_b");
        chk("irq_b_hold", 32'(b_irq), 32'd1);
        cyc1();
        chk("irq_b_drop", 32'(b_irq), 32'd0);
        rdc(1'b1, OFF_STATUS, 32'h0, "status_b_clr");

        // Asynchronous reset in the middle of a count
        vhalf = 50;
        wr(1'b0, OFF_CTRL, 32'h0F, "start_a2");
        repeat (50) cyc1();
        rdc(1'b0, OFF_STATUS, 32'h1, "busy_pre_rst");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {a_vco_en, a_vga_en, a_irq, a_gain}, 32'h0);
        chk("rst_mid_ack", 32'(ifa.wbs_ack_o), 32'h0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        rdc(1'b0, OFF_STATUS, 32'h0, "rst_status");
        rdc(1'b0, OFF_RESULT, 32'h0, "rst_result");
        rdc(1'b0, OFF_CTRL, 32'h0, "rst_ctrl");

        // WIN=0 completes at once; irq follows irq_en
        wr(1'b0, OFF_WIN, 32'h0, "win0");
        wr(1'b0, OFF_CTRL, 32'h0F, "start_win0");
        chk("irq_win0_c0", 32'(a_irq), 32'd0);
        cyc1();
        chk("irq_win0_c1", 32'(a_irq), 32'd0);
        cyc1();
        chk("irq_win0_c2", 32'(a_irq), 32'd1);
        rdc(1'b0, OFF_RESULT, 32'h0, "result_win0");
        rdc(1'b0, OFF_STATUS, 32'h2, "status_win0");
        wr(1'b0, OFF_CTRL, 32'h03, "irq_en_off");
        cyc1();
        chk("irq_masked", 32'(a_irq), 32'd0);
        rdc(1'b0, OFF_STATUS, 32'h2, "done_kept");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
